// File: rtl/freq_mon_pkg.sv
// Shared definitions for the clock frequency monitor: FSM encoding, gate counter width
// and default gate-window lengths for common system clock rates.
package freq_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    localparam int GATE_W = 32;

    localparam int unsigned GATE_CYCLES_100M = 32'd100_000_000;
    localparam int unsigned GATE_CYCLES_125M = 32'd125_000_000;

    // The gate counter counts down to zero inclusive, so it is loaded with one less than the window.
    function automatic logic [GATE_W-1:0] gate_load(input int unsigned cycles);
        return GATE_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/freq_mon_chan.sv
// One monitor channel: 2-flop synchroniser, both-edge detector, saturating edge counter, sticky overflow
// and result registers; range comparator present when FREQ_MON_LIMIT_EN is defined.
module freq_mon_chan #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tog,
    input  logic             i_clr,
    input  logic             i_cnt_en,
    input  logic             i_latch,
`ifdef FREQ_MON_LIMIT_EN
    input  logic [CNT_W-1:0] i_lim_lo,
    input  logic [CNT_W-1:0] i_lim_hi,
    output logic             o_oor,
`endif
    output logic [CNT_W-1:0] o_freq_cnt,
    output logic             o_ovf,
    output logic             o_alive,
    output logic             o_led
);

    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_int;
    logic [CNT_W-1:0] r_freq_cnt;
    logic             r_ovf;
    logic             r_alive;
    logic             w_edge;
    logic             w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_tog;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 ^ r_s3;
    assign w_sat  = &r_cnt;

    // Edges outside the gate are dropped, which also swallows the edge that follows reset release.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
        end else if (i_cnt_en && w_edge) begin
            if (w_sat) begin
                r_ovf_int <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq_cnt <= '0;
            r_ovf      <= 1'b0;
            r_alive    <= 1'b0;
        end else if (i_latch) begin
            r_freq_cnt <= r_cnt;
            r_ovf      <= r_ovf_int;
            r_alive    <= (r_cnt != '0);
        end
    end

`ifdef FREQ_MON_LIMIT_EN
    logic r_oor;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oor <= 1'b0;
        end else if (i_latch) begin
            r_oor <= (r_cnt < i_lim_lo) | (r_cnt > i_lim_hi) | r_ovf_int;
        end
    end
    assign o_oor = r_oor;
`endif

    assign o_freq_cnt = r_freq_cnt;
    assign o_ovf      = r_ovf;
    assign o_alive    = r_alive;
    assign o_led      = ~r_s2;

endmodule

// File: rtl/clk_freq_monitor.sv
// Multi-channel clock activity / frequency monitor: counts edges of each synchronised toggle bit over a
// GATE_CYCLES window and publishes counts and flags; FREQ_MON_LIMIT_EN adds per-channel range checking.
module clk_freq_monitor
    import freq_mon_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_100M
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         tog_in,
    input  logic                    start,
    input  logic                    mode_cont,
`ifdef FREQ_MON_LIMIT_EN
    input  logic [CNT_W-1:0]        lim_lo,
    input  logic [CNT_W-1:0]        lim_hi,
    output logic [N_CH-1:0]         oor,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [N_CH*CNT_W-1:0]   freq_cnt,
    output logic [N_CH-1:0]         ovf,
    output logic [N_CH-1:0]         alive,
    output logic [N_CH-1:0]         led
);

    localparam logic [GATE_W-1:0] GATE_LOAD = gate_load(GATE_CYCLES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GATE_W-1:0]   r_gate_cnt;
    logic                r_done;
    logic                w_clr;
    logic                w_cnt_en;
    logic                w_latch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // start is only looked at in IDLE, so a request during a window is simply lost.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start || mode_cont) w_state_nxt = ST_ARM;
            ST_ARM:   w_state_nxt = ST_GATE;
            ST_GATE:  if (r_gate_cnt == '0) w_state_nxt = ST_LATCH;
            ST_LATCH: w_state_nxt = mode_cont ? ST_ARM : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_clr    = (r_state == ST_ARM);
    assign w_cnt_en = (r_state == ST_GATE);
    assign w_latch  = (r_state == ST_LATCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_cnt <= '0;
        end else if (w_clr) begin
            r_gate_cnt <= GATE_LOAD;
        end else if (w_cnt_en && (r_gate_cnt != '0)) begin
            r_gate_cnt <= r_gate_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_latch;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        freq_mon_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_tog      (tog_in[g]),
            .i_clr      (w_clr),
            .i_cnt_en   (w_cnt_en),
            .i_latch    (w_latch),
`ifdef FREQ_MON_LIMIT_EN
            .i_lim_lo   (lim_lo),
            .i_lim_hi   (lim_hi),
            .o_oor      (oor[g]),
`endif
            .o_freq_cnt (freq_cnt[g*CNT_W +: CNT_W]),
            .o_ovf      (ovf[g]),
            .o_alive    (alive[g]),
            .o_led      (led[g])
        );
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor: a 32-bit-counter instance and a 4-bit-counter instance share stimulus;
// ch0 toggles every 5 clk, ch1 stuck high, ch2 every 2 clk, ch3 every 10 clk.
module tb_clk_freq_monitor;

    localparam int N_CH  = 4;
    localparam int GATE  = 1000;
    localparam int LAT   = GATE + 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mode_cont;
    logic          t0, t1, t2, t3;
    logic [3:0]    tog_in;

    logic          busy,  done;
    logic [127:0]  freq_cnt;
    logic [3:0]    ovf, alive, led;

    logic          busy_s, done_s;
    logic [15:0]   freq_cnt_s;
    logic [3:0]    ovf_s, alive_s, led_s;

`ifdef FREQ_MON_LIMIT_EN
    logic [31:0]   lim_lo, lim_hi;
    logic [3:0]    lim_lo_s, lim_hi_s;
    logic [3:0]    oor, oor_s;
`endif

    int n_checks = 0;
    int n_errors = 0;

    assign tog_in = {t3, t2, t1, t0};

    clk_freq_monitor #(.N_CH(N_CH), .CNT_W(32), .GATE_CYCLES(GATE)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .start     (start),
        .mode_cont (mode_cont),
`ifdef FREQ_MON_LIMIT_EN
        .lim_lo    (lim_lo),
        .lim_hi    (lim_hi),
        .oor       (oor),
`endif
        .busy      (busy),
        .done      (done),
        .freq_cnt  (freq_cnt),
        .ovf       (ovf),
        .alive     (alive),
        .led       (led)
    );

    clk_freq_monitor #(.N_CH(N_CH), .CNT_W(4), .GATE_CYCLES(GATE)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .start     (start),
        .mode_cont (mode_cont),
`ifdef FREQ_MON_LIMIT_EN
        .lim_lo    (lim_lo_s),
        .lim_hi    (lim_hi_s),
        .oor       (oor_s),
`endif
        .busy      (busy_s),
        .done      (done_s),
        .freq_cnt  (freq_cnt_s),
        .ovf       (ovf_s),
        .alive     (alive_s),
        .led       (led_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Toggle phases keep clear of clk edges (which fall on multiples of 5 ns).
    initial begin t0 = 1'b0; #3; forever #50  t0 = ~t0; end
    initial begin t1 = 1'b1; end
    initial begin t2 = 1'b0; #7; forever #20  t2 = ~t2; end
    initial begin t3 = 1'b0; #1; forever #100 t3 = ~t3; end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] v, input int lo, input int hi);
        return (v >= 32'(lo)) && (v <= 32'(hi));
    endfunction

    // Counts posedges until done is seen #1 after an edge; returns -1 if the budget runs out.
    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done || done_s) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int n;
        int busy_seen;

        rst       = 1'b1;
        start     = 1'b0;
        mode_cont = 1'b0;
`ifdef FREQ_MON_LIMIT_EN
        lim_lo   = 32'd190;
        lim_hi   = 32'd210;
        lim_lo_s = 4'd0;
        lim_hi_s = 4'd15;
`endif

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_freq_cnt", freq_cnt, 0);
        check("rst_ovf",      ovf,      0);
        check("rst_alive",    alive,    0);
        check("rst_led",      led,      4'hF);
`ifdef FREQ_MON_LIMIT_EN
        check("rst_oor",      oor,      0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("led_stuck_high", led[1], 0);

        // Single measurement
        pulse_start();
        busy_seen = busy;
        check("single_busy", busy_seen, 1);
        wait_done(2 * LAT, n);
        check("single_latency", n, LAT);
        check("single_busy_at_done", busy, 0);
        check("ch0_cnt_200",   in_range(freq_cnt[31:0], 199, 201), 1);
        check("ch0_alive",     alive[0], 1);
        check("ch0_ovf",       ovf[0], 0);
        check("ch1_cnt_zero",  freq_cnt[63:32], 0);
        check("ch1_alive",     alive[1], 0);
        check("ch2_cnt_500",   in_range(freq_cnt[95:64], 499, 501), 1);
        check("ch3_cnt_100",   in_range(freq_cnt[127:96], 99, 101), 1);
        check("ch3_alive",     alive[3], 1);
        check("sat_ch2_cnt",   freq_cnt_s[11:8], 15);
        check("sat_ch2_ovf",   ovf_s[2], 1);
        check("sat_ch1_ovf",   ovf_s[1], 0);
        check("sat_done",      done_s, 1);
`ifdef FREQ_MON_LIMIT_EN
        check("oor_limits",    oor, 4'b1110);
        check("oor_sat",       oor_s, 4'b1101);
`endif
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("hold_ch1_alive", alive[1], 0);
        check("hold_ch0_alive", alive[0], 1);

        // Continuous mode
        @(negedge clk);
        mode_cont = 1'b1;
        @(posedge clk);
        #1;
        wait_done(2 * LAT, n);
        check("cont_first", n, LAT);
        wait_done(2 * LAT, n);
        check("cont_period", n, LAT);
        check("cont_busy", busy, 1);
        repeat (500) @(posedge clk);
        @(negedge clk);
        mode_cont = 1'b0;
        wait_done(2 * LAT, n);
        check("cont_last", n, LAT - 500);
        check("cont_end_busy", busy, 0);
        expect_quiet("cont_no_more_done", LAT + 100);

        // Start during GATE is ignored
        pulse_start();
        repeat (300) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2 * LAT, n);
        check("ign_latency", n, LAT - 301);
        expect_quiet("ign_no_extra", LAT + 100);
        check("ign_busy", busy, 0);

        // Reset mid-window aborts
        pulse_start();
        repeat (500) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",     busy, 0);
        check("abort_done",     done, 0);
        check("abort_freq_cnt", freq_cnt, 0);
        check("abort_alive",    alive, 0);
        check("abort_sat_ovf",  ovf_s, 0);
        check("abort_led",      led, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("abort_no_done", LAT + 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
